// File: rtl/baud_gen_frac.sv
// Fractional-N UART baud generator.
// Produces an oversampled sample_tick, a bit_tick on the last sample index,
// a mid_tick on sample index OVERSAMPLE/2-1 and a 50% duty baud_clk.
// Each sample period lasts D clocks, or D+1 when the fractional accumulator
// carried on the tick that started it. D and F come from four elaborated
// presets or from a runtime custom divisor.
// Ports:
//   clock, reset_n            system clock, async active-low reset
//   enable                    run the generator; low holds it idle
//   baud_rate[1:0]            preset: 00=2400 01=4800 10=9600 11=19200
//   use_custom                select custom_div/custom_frac instead of preset
//   custom_div[DIV_W-1:0]     integer clocks per sample tick (clamped to >=2)
//   custom_frac[FRAC_W-1:0]   fractional clocks per tick, in 1/2^FRAC_W
//   sync_clear                one-cycle pulse that restarts the phase from zero
//   sample_tick               one-cycle pulse per oversample period
//   bit_tick                  pulse on the tick that completes index OVERSAMPLE-1
//   mid_tick                  pulse on the tick that completes index OVERSAMPLE/2-1
//   baud_clk                  high while sample index is below OVERSAMPLE/2
module baud_gen_frac #(
    parameter int unsigned CLK_FREQ   = 50_000_000,
    parameter int unsigned OVERSAMPLE = 16,
    parameter int unsigned DIV_W      = 16,
    parameter int unsigned FRAC_W     = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              enable,
    input  logic [1:0]        baud_rate,
    input  logic              use_custom,
    input  logic [DIV_W-1:0]  custom_div,
    input  logic [FRAC_W-1:0] custom_frac,
    input  logic              sync_clear,
    output logic              sample_tick,
    output logic              bit_tick,
    output logic              mid_tick,
    output logic              baud_clk
);

    localparam int unsigned IDX_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(OVERSAMPLE - 1);
    localparam logic [IDX_W-1:0] IDX_MID  = IDX_W'(OVERSAMPLE / 2 - 1);
    localparam logic [IDX_W-1:0] IDX_HALF = IDX_W'(OVERSAMPLE / 2);

    // Rounded clocks-per-tick in fixed point: round(CLK_FREQ*2^FRAC_W/(rate*OS)).
    function automatic logic [63:0] preset_x(input logic [63:0] rate);
        logic [63:0] num;
        logic [63:0] den;
        num = 64'(CLK_FREQ) << (FRAC_W + 1);
        den = rate * 64'(OVERSAMPLE);
        return (num / den + 64'd1) >> 1;
    endfunction

    localparam logic [63:0] X_2400  = preset_x(64'd2400);
    localparam logic [63:0] X_4800  = preset_x(64'd4800);
    localparam logic [63:0] X_9600  = preset_x(64'd9600);
    localparam logic [63:0] X_19200 = preset_x(64'd19200);

    localparam logic [DIV_W-1:0]  D_2400  = DIV_W'(X_2400 >> FRAC_W);
    localparam logic [DIV_W-1:0]  D_4800  = DIV_W'(X_4800 >> FRAC_W);
    localparam logic [DIV_W-1:0]  D_9600  = DIV_W'(X_9600 >> FRAC_W);
    localparam logic [DIV_W-1:0]  D_19200 = DIV_W'(X_19200 >> FRAC_W);
    localparam logic [FRAC_W-1:0] F_2400  = FRAC_W'(X_2400);
    localparam logic [FRAC_W-1:0] F_4800  = FRAC_W'(X_4800);
    localparam logic [FRAC_W-1:0] F_9600  = FRAC_W'(X_9600);
    localparam logic [FRAC_W-1:0] F_19200 = FRAC_W'(X_19200);

    logic [DIV_W-1:0]  cnt;
    logic [FRAC_W-1:0] acc;
    logic [IDX_W-1:0]  idx;
    logic [DIV_W-1:0]  cfg_d;
    logic              en_q;

    logic [DIV_W-1:0]  sel_d;
    logic [FRAC_W-1:0] sel_f;
    logic [FRAC_W:0]   acc_sum;
    logic [DIV_W-1:0]  reload;
    logic              restart;
    logic              tick;

    // Divisor selection; custom divisors below 2 are clamped to 2.
    always_comb begin
        sel_d = D_2400;
        sel_f = F_2400;
        if (use_custom) begin
            sel_d = (custom_div < DIV_W'(2)) ? DIV_W'(2) : custom_div;
            sel_f = custom_frac;
        end else begin
            case (baud_rate)
                2'b00:   begin sel_d = D_2400;  sel_f = F_2400;  end
                2'b01:   begin sel_d = D_4800;  sel_f = F_4800;  end
                2'b10:   begin sel_d = D_9600;  sel_f = F_9600;  end
                default: begin sel_d = D_19200; sel_f = F_19200; end
            endcase
        end
    end

    // F is only consumed at the tick where it is latched, so the live
    // selection is used directly; the carry stretches the period that starts now.
    always_comb begin
        acc_sum = {1'b0, acc} + {1'b0, sel_f};
        reload  = acc_sum[FRAC_W] ? sel_d : sel_d - DIV_W'(1);
        restart = enable & (~en_q | sync_clear);
        tick    = enable & ~restart & (cnt == '0);
    end

    // Period counter, fractional accumulator, sample index and outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            cnt         <= D_2400 - DIV_W'(1);
            acc         <= '0;
            idx         <= '0;
            cfg_d       <= D_2400;
            en_q        <= 1'b0;
            sample_tick <= 1'b0;
            bit_tick    <= 1'b0;
            mid_tick    <= 1'b0;
            baud_clk    <= 1'b0;
        end else begin
            en_q        <= enable;
            sample_tick <= tick;
            bit_tick    <= tick & (idx == IDX_LAST);
            mid_tick    <= tick & (idx == IDX_MID);
            baud_clk    <= enable & (idx < IDX_HALF);
            if (!enable) begin
                cnt <= cfg_d - DIV_W'(1);
                acc <= '0;
                idx <= '0;
            end else if (restart) begin
                cfg_d <= sel_d;
                cnt   <= sel_d - DIV_W'(1);
                acc   <= '0;
                idx   <= '0;
            end else if (tick) begin
                cfg_d <= sel_d;
                cnt   <= reload;
                acc   <= acc_sum[FRAC_W-1:0];
                idx   <= (idx == IDX_LAST) ? '0 : idx + IDX_W'(1);
            end else begin
                cnt <= cnt - DIV_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_baud_gen_frac.sv
// Self-checking bench for baud_gen_frac: a timestamp model predicts every
// output each cycle, and directed phases pin latencies and periods to
// hand-computed constants.
module tb_baud_gen_frac;

    localparam int unsigned CLK_FREQ = 50_000_000;
    localparam int unsigned OS       = 16;
    localparam int unsigned DIV_W    = 16;
    localparam int unsigned FRAC_W   = 4;

    logic              clock = 1'b0;
    logic              reset_n;
    logic              enable;
    logic [1:0]        baud_rate;
    logic              use_custom;
    logic [DIV_W-1:0]  custom_div;
    logic [FRAC_W-1:0] custom_frac;
    logic              sync_clear;
    logic              sample_tick;
    logic              bit_tick;
    logic              mid_tick;
    logic              baud_clk;

    int     total = 0;
    int     bad   = 0;
    longint cyc   = 0;
    longint tick_q[$];
    longint bit_q[$];
    longint mid_q[$];
    bit     tbaud_q[$];

    longint m_due;
    int     m_k;
    int     m_acc;
    bit     m_en_q;

    baud_gen_frac #(
        .CLK_FREQ(CLK_FREQ), .OVERSAMPLE(OS), .DIV_W(DIV_W), .FRAC_W(FRAC_W)
    ) dut (
        .clock(clock), .reset_n(reset_n), .enable(enable), .baud_rate(baud_rate),
        .use_custom(use_custom), .custom_div(custom_div), .custom_frac(custom_frac),
        .sync_clear(sync_clear), .sample_tick(sample_tick), .bit_tick(bit_tick),
        .mid_tick(mid_tick), .baud_clk(baud_clk)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    // Fixed-point clocks per tick from real arithmetic on the nominal rate.
    function automatic int rate_x(input logic [1:0] r);
        real rate;
        rate = 2400.0 * real'(1 << r);
        return $rtoi(real'(CLK_FREQ) * real'(1 << FRAC_W) / (rate * real'(OS)) + 0.5);
    endfunction

    function automatic int m_d();
        if (use_custom) return (custom_div < 2) ? 2 : int'(custom_div);
        return rate_x(baud_rate) / (1 << FRAC_W);
    endfunction

    function automatic int m_f();
        if (use_custom) return int'(custom_frac);
        return rate_x(baud_rate) % (1 << FRAC_W);
    endfunction

    function automatic int qsize(input int which);
        case (which)
            0:       return tick_q.size();
            1:       return bit_q.size();
            default: return mid_q.size();
        endcase
    endfunction

    task automatic clear_q();
        tick_q.delete();
        bit_q.delete();
        mid_q.delete();
        tbaud_q.delete();
    endtask

    task automatic wait_n(input string name, input int which, input int n, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (qsize(which) >= n) break;
            @(negedge clock);
        end
        check(name, 64'(qsize(which) >= n), 64'd1);
    endtask

    // Model: next tick time is a timestamp; the period index is the tick count mod OS.
    initial begin : model
        logic [3:0] expv;
        bit t, b, m, bc;
        int ext;
        m_en_q = 1'b0;
        m_k    = 0;
        m_acc  = 0;
        m_due  = 0;
        forever begin
            @(posedge clock);
            cyc++;
            t = 1'b0; b = 1'b0; m = 1'b0; bc = 1'b0;
            if (!reset_n) begin
                m_en_q = 1'b0;
                m_k    = 0;
                m_acc  = 0;
            end else begin
                bc = enable && ((m_k % OS) < OS / 2);
                if (!enable) begin
                    m_k   = 0;
                    m_acc = 0;
                end else if (!m_en_q || sync_clear) begin
                    m_due = cyc + m_d();
                    m_k   = 0;
                    m_acc = 0;
                end else if (cyc == m_due) begin
                    t = 1'b1;
                    b = (m_k % OS) == OS - 1;
                    m = (m_k % OS) == OS / 2 - 1;
                    m_k++;
                    m_acc = m_acc + m_f();
                    ext   = (m_acc >= (1 << FRAC_W)) ? 1 : 0;
                    m_acc = m_acc % (1 << FRAC_W);
                    m_due = cyc + m_d() + ext;
                end
                m_en_q = enable;
            end
            expv = {t, b, m, bc};
            #1;
            check("cycle_outputs", 64'({sample_tick, bit_tick, mid_tick, baud_clk}), 64'(expv));
            if (sample_tick) begin
                tick_q.push_back(cyc);
                tbaud_q.push_back(baud_clk);
            end
            if (bit_tick) bit_q.push_back(cyc);
            if (mid_tick) mid_q.push_back(cyc);
        end
    end

    initial begin : stim
        longint t0;
        longint prev;
        longint sc;
        int     n_long;
        int     n_short;
        int     n_high;

        reset_n = 1'b0; enable = 1'b1; baud_rate = 2'b00; use_custom = 1'b0;
        custom_div = '0; custom_frac = '0; sync_clear = 1'b0;

        // 1: reset held with enable high, then release at 2400
        repeat (5) @(negedge clock);
        check("t1_reset_outputs", 64'({sample_tick, bit_tick, mid_tick, baud_clk}), 64'd0);
        clear_q();
        reset_n = 1'b1;
        t0 = cyc + 1;
        wait_n("t1_wait_tick", 0, 1, 2000);
        check("t1_first_tick_latency", 64'(tick_q[0] - t0), 64'd1302);

        // 2: 9600, first bit and steady bit period
        enable = 1'b0;
        repeat (3) @(negedge clock);
        baud_rate = 2'b10;
        clear_q();
        enable = 1'b1;
        t0 = cyc + 1;
        wait_n("t2_wait_bits", 1, 2, 12000);
        check("t2_first_tick_latency", 64'(tick_q[0] - t0), 64'd325);
        check("t2_mid_on_8th", 64'(mid_q[0]), 64'(tick_q[7]));
        check("t2_bit_on_16th", 64'(bit_q[0]), 64'(tick_q[15]));
        check("t2_bit_period", 64'(bit_q[1] - bit_q[0]), 64'd5208);
        n_long = 0; n_short = 0;
        for (int i = 1; i <= 16; i++) begin
            if (tick_q[i] - tick_q[i-1] == 326) n_long++;
            if (tick_q[i] - tick_q[i-1] == 325) n_short++;
        end
        check("t2_periods_326", 64'(n_long), 64'd8);
        check("t2_periods_325", 64'(n_short), 64'd8);

        // 3: switch to 19200 on the fly, measure a whole bit window
        baud_rate = 2'b11;
        clear_q();
        wait_n("t3_wait_first_bit", 1, 1, 8000);
        prev = bit_q[0];
        clear_q();
        wait_n("t3_wait_next_bit", 1, 1, 4000);
        check("t3_bit_period", 64'(bit_q[0] - prev), 64'd2604);
        check("t3_ticks_per_bit", 64'(tick_q.size()), 64'd16);
        n_high = 0;
        foreach (tbaud_q[i]) if (tbaud_q[i]) n_high++;
        check("t3_baud_high_ticks", 64'(n_high), 64'd8);

        // 4: custom div=1 clamps to 2; then 10 + 8/16 alternates 10/11
        use_custom = 1'b1; custom_div = 16'd1; custom_frac = 4'd0;
        sync_clear = 1'b1;
        clear_q();
        t0 = cyc + 1;
        @(negedge clock);
        sync_clear = 1'b0;
        wait_n("t4_wait_clamp", 0, 6, 100);
        check("t4_clamp_latency", 64'(tick_q[0] - t0), 64'd2);
        check("t4_clamp_period_a", 64'(tick_q[4] - tick_q[3]), 64'd2);
        check("t4_clamp_period_b", 64'(tick_q[5] - tick_q[4]), 64'd2);
        custom_div = 16'd10; custom_frac = 4'd8;
        clear_q();
        wait_n("t4_wait_frac", 0, 6, 200);
        check("t4_frac_period_1", 64'(tick_q[1] - tick_q[0]), 64'd10);
        check("t4_frac_period_2", 64'(tick_q[2] - tick_q[1]), 64'd11);
        check("t4_frac_period_3", 64'(tick_q[3] - tick_q[2]), 64'd10);

        // 5: sync_clear on the cycle the counter reaches zero
        for (int i = 0; i < 50; i++) begin
            if (m_due == cyc + 1) break;
            @(negedge clock);
        end
        check("t5_found_zero_cycle", 64'(m_due == cyc + 1), 64'd1);
        sync_clear = 1'b1;
        sc = cyc + 1;
        clear_q();
        @(negedge clock);
        sync_clear = 1'b0;
        wait_n("t5_wait_mid", 2, 1, 300);
        check("t5_first_tick_after_sync", 64'(tick_q[0] - sc), 64'd10);
        check("t5_mid_after_sync", 64'(mid_q[0] - sc), 64'd83);

        // 6: async reset while sample_tick is high, then 100 idle clocks
        for (int i = 0; i < 50; i++) begin
            if (m_due == cyc + 1) break;
            @(negedge clock);
        end
        @(posedge clock);
        #3;
        check("t6_tick_before_reset", 64'(sample_tick), 64'd1);
        reset_n = 1'b0;
        #1;
        check("t6_async_reset_outputs", 64'({sample_tick, bit_tick, mid_tick, baud_clk}), 64'd0);
        enable = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        clear_q();
        repeat (100) @(negedge clock);
        check("t6_idle_tick_count", 64'(tick_q.size()), 64'd0);
        check("t6_idle_baud_clk", 64'(baud_clk), 64'd0);
        enable = 1'b1;
        t0 = cyc + 1;
        wait_n("t6_wait_resume", 0, 1, 100);
        check("t6_resume_latency", 64'(tick_q[0] - t0), 64'd10);

        repeat (3) @(negedge clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
